snn_neuron_ctrl: RTL and testbench

Sequencer for one integrate-and-fire neuron built around the membrane accumulator.
- Per timestep: latches an input spike vector, scans it axon by axon, reads the synaptic weight of each active axon from an external weight RAM, and feeds each weight to the accumulator.
- After the scan: compares the membrane against a threshold, emits an output spike, and clears the membrane on fire.
- Sits between the timestep scheduler (start/done) and the accumulator plus weight RAM.

---
 rtl/snn_pkg.sv | 19 +
 rtl/snn_neuron_ctrl.sv | 160 ++++++++++++++++
 tb/tb_snn_neuron_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the integrate-and-fire neuron slice.
//   state_t      : sequencer states (IDLE, SCAN, DRAIN, FIRE)
//   *_DEF        : default NIN / WID / SYNWID
//   W_RD_LAT     : weight RAM read latency in cycles (data valid 1 cycle after w_rd)
package snn_pkg;

  localparam int unsigned NIN_DEF    = 16;
  localparam int unsigned WID_DEF    = 12;
  localparam int unsigned SYNWID_DEF = 8;
  localparam int unsigned W_RD_LAT   = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    FIRE  = 2'd3
  } state_t;

endpackage

// File: rtl/snn_neuron_ctrl.sv
// Sequencer for one integrate-and-fire neuron.
// Each timestep latches a spike vector and threshold, scans every axon
// (one per cycle), reads the weight of each active axon from an external
// RAM and feeds it to an external membrane accumulator, then compares the
// membrane with the threshold, emits a spike and clears the membrane on fire.
//
// Optional build macro: SAT_ACC_EN -- drops any weight that would overflow
// the membrane and raises the sticky sat flag. Without it sat is tied 0 and
// the membrane wraps modulo 2^WID.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          begin timestep (sampled only in IDLE)
//   spike_in       input spike vector, sampled with start
//   threshold      firing threshold, sampled with start
//   soft_clr       membrane clear request (honoured only in IDLE)
//   busy           high outside IDLE
//   done           one-cycle pulse at end of timestep
//   spike_out      one-cycle pulse with done when the neuron fired
//   w_rd, w_addr   weight RAM read strobe / address
//   w_data         weight RAM data, valid one cycle after w_rd
//   acc_clr        accumulator clear
//   acc_valid      accumulator add strobe
//   acc_data       accumulator addend
//   acc            current membrane value
//   sat            sticky overflow flag (SAT_ACC_EN only)
module snn_neuron_ctrl
  import snn_pkg::*;
#(
  parameter int unsigned NIN    = NIN_DEF,
  parameter int unsigned WID    = WID_DEF,
  parameter int unsigned SYNWID = SYNWID_DEF,
  parameter int unsigned AW     = $clog2(NIN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NIN-1:0]    spike_in,
  input  logic [WID-1:0]    threshold,
  input  logic              soft_clr,
  output logic              busy,
  output logic              done,
  output logic              spike_out,
  output logic              w_rd,
  output logic [AW-1:0]     w_addr,
  input  logic [SYNWID-1:0] w_data,
  output logic              acc_clr,
  output logic              acc_valid,
  output logic [SYNWID-1:0] acc_data,
  input  logic [WID-1:0]    acc,
  output logic              sat
);

  localparam int unsigned DW = (W_RD_LAT > 1) ? $clog2(W_RD_LAT) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(NIN - 1);
  localparam logic [DW-1:0] LAST_DRN = DW'(W_RD_LAT - 1);

  state_t         state_q, state_d;
  logic [NIN-1:0] svec;
  logic [WID-1:0] thr;
  logic [AW-1:0]  idx;
  logic [DW-1:0]  drn;
  logic           pend;
  logic           fire;
  logic           idle_clr;
  logic           drop;

  assign busy     = (state_q != IDLE);
  assign w_addr   = idx;
  assign acc_data = w_data;
  assign idle_clr = (state_q == IDLE) && soft_clr;

  always_comb begin
    state_d = state_q;
    w_rd    = 1'b0;
    fire    = 1'b0;
    acc_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        acc_clr = soft_clr;
        if (start) state_d = SCAN;
      end
      SCAN: begin
        w_rd = svec[idx];
        if (idx == LAST_IDX) state_d = DRAIN;
      end
      DRAIN: begin
        if (drn == LAST_DRN) state_d = FIRE;
      end
      FIRE: begin
        fire    = (acc >= thr);
        acc_clr = fire;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SAT_ACC_EN
  logic [WID:0] sum_ext;
  logic         sat_q;

  assign sum_ext   = {1'b0, acc} + (WID+1)'(w_data);
  assign drop      = pend && sum_ext[WID];
  assign acc_valid = pend && !drop;
  assign sat       = sat_q;

  // A drop can only occur in SCAN/DRAIN, so it never coincides with the
  // IDLE soft clear or the FIRE clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else if (idle_clr || fire) begin
      sat_q <= 1'b0;
    end else if (drop) begin
      sat_q <= 1'b1;
    end
  end
`else
  assign drop      = 1'b0;
  assign acc_valid = pend;
  assign sat       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      svec      <= '0;
      thr       <= '0;
      idx       <= '0;
      drn       <= '0;
      pend      <= 1'b0;
      done      <= 1'b0;
      spike_out <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend      <= w_rd;
      done      <= (state_q == FIRE);
      spike_out <= fire;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            svec <= spike_in;
            thr  <= threshold;
            idx  <= '0;
          end
        end
        SCAN: begin
          drn <= '0;
          // Index holds at the last axon rather than wrapping; the next
          // start reloads it.
          if (idx != LAST_IDX) idx <= idx + 1'b1;
        end
        DRAIN: drn <= drn + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_neuron_ctrl.sv
module tb_snn_neuron_ctrl;
  import snn_pkg::*;

  localparam int unsigned NIN    = 16;
  localparam int unsigned WID    = 12;
  localparam int unsigned SYNWID = 8;
  localparam int unsigned AW     = 4;
  localparam int unsigned MAXM   = (1 << WID) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [NIN-1:0]    spike_in = '0;
  logic [WID-1:0]    threshold = '0;
  logic              soft_clr = 1'b0;
  logic              busy, done, spike_out, w_rd, acc_clr, acc_valid, sat;
  logic [AW-1:0]     w_addr;
  logic [SYNWID-1:0] w_data;
  logic [SYNWID-1:0] acc_data;
  logic [WID-1:0]    acc;

  always #5 clk = ~clk;

  snn_neuron_ctrl #(.NIN(NIN), .WID(WID), .SYNWID(SYNWID), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .spike_in(spike_in),
    .threshold(threshold), .soft_clr(soft_clr), .busy(busy), .done(done),
    .spike_out(spike_out), .w_rd(w_rd), .w_addr(w_addr), .w_data(w_data),
    .acc_clr(acc_clr), .acc_valid(acc_valid), .acc_data(acc_data),
    .acc(acc), .sat(sat)
  );

  // Environment: weight RAM with one-cycle read latency, membrane accumulator.
  logic [SYNWID-1:0] wmem [NIN];

  always @(posedge clk) if (w_rd) w_data <= wmem[w_addr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)         acc <= '0;
    else if (acc_clr)   acc <= '0;
    else if (acc_valid) acc <= acc + WID'(acc_data);
  end

  int n_pass = 0;
  int n_total = 0;

  // Reference neuron: membrane as a plain integer.
  int unsigned m_mem = 0;
  bit          m_sat = 1'b0;
  int unsigned exp_pre, exp_nacc;
  bit          exp_fire;

  task automatic model_ts(input logic [NIN-1:0] sp, input int unsigned th,
                          input bit clr_first);
    if (clr_first) begin m_mem = 0; m_sat = 1'b0; end
    exp_nacc = 0;
    for (int i = 0; i < NIN; i++) begin
      if (sp[i]) begin
        int unsigned w;
        w = wmem[i];
`ifdef SAT_ACC_EN
        if (m_mem + w > MAXM) m_sat = 1'b1;
        else begin m_mem = m_mem + w; exp_nacc++; end
`else
        m_mem = (m_mem + w) % (MAXM + 1);
        exp_nacc++;
`endif
      end
    end
    exp_pre  = m_mem;
    exp_fire = (m_mem >= th);
    if (exp_fire) begin m_mem = 0; m_sat = 1'b0; end
  endtask

  task automatic set_ramp_weights();
    for (int i = 0; i < NIN; i++) wmem[i] = SYNWID'(i + 1);
  endtask

  // One timestep from IDLE; called at posedge+1.
  task automatic run_ts(input string tag, input logic [NIN-1:0] sp,
                        input logic [WID-1:0] th, input bit clr_with_start,
                        input bit mid_start, input bit noise);
    int n = 0, nrd = 0, nval = 0;
    bit addr_ok = 1'b1;
    logic [WID-1:0] fire_acc = '0;
    logic fire_clr = 1'b0;
    model_ts(sp, th, clr_with_start);
    spike_in = sp; threshold = th; start = 1'b1; soft_clr = clr_with_start;
    @(posedge clk); #1;
    start = 1'b0; soft_clr = 1'b0;
    spike_in = NIN'($urandom); threshold = WID'($urandom);
    while (!done && n < NIN + 10) begin
      if (w_rd) begin
        nrd++;
        if (w_addr != AW'(n)) addr_ok = 1'b0;
      end
      if (acc_valid) nval++;
      if (n == NIN + 1) begin fire_acc = acc; fire_clr = acc_clr; end
      start    = mid_start && (n == 5);
      soft_clr = noise && (n < NIN + 1) && ($urandom_range(0, 1) == 1);
      @(posedge clk); #1;
      n++;
    end
    soft_clr = 1'b0; start = 1'b0;
    n_total++;
    if (!(done === 1'b1 && n == NIN + 2))
      $display("FAIL %s latency: done=%b at edge %0d, required 1 at edge %0d", tag, done, n, NIN + 2);
    else n_pass++;
    n_total++;
    if (nrd != $countones(sp))
      $display("FAIL %s reads: %0d w_rd cycles, required %0d", tag, nrd, $countones(sp));
    else n_pass++;
    n_total++;
    if (nval != exp_nacc)
      $display("FAIL %s acc_valid: %0d cycles, required %0d", tag, nval, exp_nacc);
    else n_pass++;
    n_total++;
    if (!addr_ok) $display("FAIL %s w_addr: address did not track axon index, required index", tag);
    else n_pass++;
    n_total++;
    if (fire_acc !== WID'(exp_pre) || fire_clr !== exp_fire)
      $display("FAIL %s fire: acc=%0d acc_clr=%b, required acc=%0d acc_clr=%b", tag, fire_acc, fire_clr, exp_pre, exp_fire);
    else n_pass++;
    n_total++;
    if (spike_out !== exp_fire)
      $display("FAIL %s spike_out: %b, required %b", tag, spike_out, exp_fire);
    else n_pass++;
    n_total++;
    if (acc !== WID'(m_mem) || sat !== m_sat)
      $display("FAIL %s membrane: acc=%0d sat=%b, required acc=%0d sat=%b", tag, acc, sat, m_mem, m_sat);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (done !== 1'b0 || spike_out !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s pulse: done=%b spike_out=%b busy=%b, required 0 0 0", tag, done, spike_out, busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_total++;
    if ({busy, done, spike_out, w_rd, w_addr, acc_clr, acc_valid, sat} !== '0)
      $display("FAIL reset: outputs %b, required all 0",
               {busy, done, spike_out, w_rd, w_addr, acc_clr, acc_valid, sat});
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0 || acc !== '0)
      $display("FAIL post_reset: busy=%b done=%b acc=%0d, required 0 0 0", busy, done, acc);
    else n_pass++;
  endtask

  task automatic test_directed();
    set_ramp_weights();
    run_ts("no_spikes", '0, WID'(1), 1'b0, 1'b0, 1'b0);
    run_ts("fire_0005", NIN'(16'h0005), WID'(4), 1'b0, 1'b0, 1'b0);
    run_ts("hold_0005", NIN'(16'h0005), WID'(5), 1'b0, 1'b0, 1'b0);
    n_total++;
    if (acc !== WID'(4)) $display("FAIL integrate: acc=%0d, required 4", acc);
    else n_pass++;
    run_ts("fire_0001", NIN'(16'h0001), WID'(5), 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_soft_clr();
    run_ts("build", NIN'(16'h00F0), WID'(MAXM), 1'b0, 1'b0, 1'b0);
    n_total++;
    if (acc_clr !== 1'b0) $display("FAIL idle_no_clr: acc_clr=%b, required 0", acc_clr);
    else n_pass++;
    soft_clr = 1'b1;
    #1;
    n_total++;
    if (acc_clr !== 1'b1) $display("FAIL idle_clr: acc_clr=%b, required 1", acc_clr);
    else n_pass++;
    @(posedge clk); #1;
    soft_clr = 1'b0;
    m_mem = 0; m_sat = 1'b0;
    n_total++;
    if (acc !== '0) $display("FAIL soft_clr: acc=%0d, required 0", acc);
    else n_pass++;
    run_ts("build2", NIN'(16'h0300), WID'(MAXM), 1'b0, 1'b0, 1'b0);
    run_ts("clr_and_start", NIN'(16'h0003), WID'(MAXM), 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [NIN-1:0] sps [3];
    logic [WID-1:0] ths [3];
    bit efire [3];
    int dedge [3];
    int k = 0, n = 0;
    set_ramp_weights();
    for (int j = 0; j < 3; j++) begin
      sps[j] = NIN'($urandom);
      ths[j] = WID'($urandom_range(0, 300));
      model_ts(sps[j], ths[j], 1'b0);
      efire[j] = exp_fire;
    end
    spike_in = sps[0]; threshold = ths[0]; start = 1'b1;
    @(posedge clk); #1;
    while (k < 3 && n < 3 * (NIN + 3) + 10) begin
      if (done) begin
        dedge[k] = n;
        n_total++;
        if (spike_out !== efire[k])
          $display("FAIL b2b_spike%0d: %b, required %b", k, spike_out, efire[k]);
        else n_pass++;
        k++;
        if (k < 3) begin spike_in = sps[k]; threshold = ths[k]; end
        else start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    n_total++;
    if (k != 3) $display("FAIL b2b_count: %0d done pulses, required 3", k);
    else n_pass++;
    for (int j = 0; j < k; j++) begin
      n_total++;
      if (dedge[j] != (NIN + 2) + j * (NIN + 3))
        $display("FAIL b2b_period%0d: done at edge %0d, required %0d", j, dedge[j], (NIN + 2) + j * (NIN + 3));
      else n_pass++;
    end
    n_total++;
    if (acc !== WID'(m_mem)) $display("FAIL b2b_membrane: acc=%0d, required %0d", acc, m_mem);
    else n_pass++;
  endtask

  task automatic test_reset_mid_scan();
    int seen = 0;
    set_ramp_weights();
    spike_in = '1; threshold = WID'(MAXM); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    n_total++;
    if (busy !== 1'b1 || w_rd !== 1'b1)
      $display("FAIL pre_abort: busy=%b w_rd=%b, required 1 1", busy, w_rd);
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_total++;
    if (busy !== 1'b0 || w_rd !== 1'b0 || acc_valid !== 1'b0 || acc !== '0)
      $display("FAIL abort: busy=%b w_rd=%b acc_valid=%b acc=%0d, required 0 0 0 0", busy, w_rd, acc_valid, acc);
    else n_pass++;
    m_mem = 0; m_sat = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (NIN + 5) begin
      if (done || spike_out) seen++;
      @(posedge clk); #1;
    end
    n_total++;
    if (seen != 0) $display("FAIL abort_done: %0d done/spike cycles, required 0", seen);
    else n_pass++;
    run_ts("after_abort", NIN'(16'h8001), WID'(17), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < NIN; i++) wmem[i] = '1;
    run_ts("sat_fill", '1, WID'(MAXM), 1'b1, 1'b0, 1'b0);
    wmem[3] = SYNWID'(10);
    run_ts("sat_4090", NIN'(1 << 3), WID'(MAXM), 1'b0, 1'b0, 1'b0);
    run_ts("sat_over", NIN'(1 << 5), WID'(MAXM), 1'b0, 1'b0, 1'b0);
`ifdef SAT_ACC_EN
    n_total++;
    if (acc !== WID'(4090) || sat !== 1'b1)
      $display("FAIL sat_guard: acc=%0d sat=%b, required 4090 1", acc, sat);
    else n_pass++;
`else
    n_total++;
    if (acc !== WID'(249) || sat !== 1'b0)
      $display("FAIL wrap: acc=%0d sat=%b, required 249 0", acc, sat);
    else n_pass++;
`endif
    soft_clr = 1'b1;
    @(posedge clk); #1;
    soft_clr = 1'b0;
    m_mem = 0; m_sat = 1'b0;
    n_total++;
    if (sat !== 1'b0 || acc !== '0)
      $display("FAIL sat_clear: sat=%b acc=%0d, required 0 0", sat, acc);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < NIN; i++) wmem[i] = SYNWID'($urandom);
      run_ts($sformatf("rand%0d", t), NIN'($urandom),
             WID'($urandom_range(0, 3000)), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_soft_clr();
    test_back_to_back();
    test_reset_mid_scan();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
